// File: rtl/tdc_sample_accum.sv
// tdc_sample_accum: accumulates a burst of TDC pop counts into sum/avg/min/max behind a valid/ready handshake
module tdc_sample_accum #(
   parameter int N = 64,
   parameter int LOG2_SAMPLES = 4,
   localparam int CNT_W = $clog2(N) + 1,
   localparam int SUM_W = CNT_W + LOG2_SAMPLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             sample_valid,
   input  logic [CNT_W-1:0] sample,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] sum_out,
   output logic [CNT_W-1:0] avg_out,
   output logic [CNT_W-1:0] min_out,
   output logic [CNT_W-1:0] max_out,
   output logic             ovr_out
);
   localparam logic [CNT_W-1:0] N_C = CNT_W'(N);
   localparam logic [LOG2_SAMPLES:0] LAST = (LOG2_SAMPLES+1)'((1 << LOG2_SAMPLES) - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   state_t state;

   logic [SUM_W-1:0]        acc_sum, nsum;
   logic [CNT_W-1:0]        acc_min, acc_max, clamped, nmin, nmax;
   logic                    acc_ovr, over;
   logic [LOG2_SAMPLES:0]   cnt;

   always_comb begin
      over    = sample > N_C;
      clamped = over ? N_C : sample;
      nsum    = acc_sum + SUM_W'(clamped);
      nmin    = clamped < acc_min ? clamped : acc_min;
      nmax    = clamped > acc_max ? clamped : acc_max;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         sum_out   <= '0;
         avg_out   <= '0;
         min_out   <= '0;
         max_out   <= '0;
         ovr_out   <= 1'b0;
         acc_sum   <= '0;
         acc_min   <= '0;
         acc_max   <= '0;
         acc_ovr   <= 1'b0;
         cnt       <= '0;
      end else if (abort) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         acc_sum   <= '0;
         acc_min   <= N_C;
         acc_max   <= '0;
         acc_ovr   <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state   <= ACCUM;
               busy    <= 1'b1;
               acc_sum <= '0;
               acc_min <= N_C;
               acc_max <= '0;
               acc_ovr <= 1'b0;
               cnt     <= '0;
            end
            ACCUM: if (sample_valid) begin
               acc_sum <= nsum;
               acc_min <= nmin;
               acc_max <= nmax;
               acc_ovr <= acc_ovr | over;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // results publish on the same edge that accepts the final sample
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  sum_out   <= nsum;
                  avg_out   <= nsum[SUM_W-1:LOG2_SAMPLES];
                  min_out   <= nmin;
                  max_out   <= nmax;
                  ovr_out   <= acc_ovr | over;
               end
            end
            HOLD: if (out_ready) begin
               state     <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ASSERT_ON
   localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(N << LOG2_SAMPLES);
   a_valid_hold: assert property (@(posedge clk) disable iff (!rst) out_valid |-> state == HOLD);
   a_stable: assert property (@(posedge clk) disable iff (!rst)
      out_valid && !out_ready |=> $stable({sum_out, avg_out, min_out, max_out, ovr_out}));
   a_sum_max: assert property (@(posedge clk) disable iff (!rst) sum_out <= SUM_MAX);
`endif
endmodule

// File: tb/tb_tdc_sample_accum.sv
// tb_tdc_sample_accum: directed checks of burst accumulation for LOG2_SAMPLES=2 and 4
module tb_tdc_sample_accum;
   logic clk = 1'b0, rst = 1'b0;
   logic start2 = 1'b0, start4 = 1'b0, abort = 1'b0, sample_valid = 1'b0, out_ready = 1'b0;
   logic [6:0] sample = '0;
   logic o2_busy, o2_valid, o4_busy, o4_valid;
   logic [8:0] o2_sum;
   logic [10:0] o4_sum;
   logic [6:0] o2_avg, o2_min, o2_max, o4_avg, o4_min, o4_max;
   logic o2_ovr, o4_ovr;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   tdc_sample_accum #(.N(64), .LOG2_SAMPLES(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort), .sample_valid(sample_valid),
      .sample(sample), .busy(o2_busy), .out_valid(o2_valid), .out_ready(out_ready),
      .sum_out(o2_sum), .avg_out(o2_avg), .min_out(o2_min), .max_out(o2_max), .ovr_out(o2_ovr));

   tdc_sample_accum #(.N(64), .LOG2_SAMPLES(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort), .sample_valid(sample_valid),
      .sample(sample), .busy(o4_busy), .out_valid(o4_valid), .out_ready(out_ready),
      .sum_out(o4_sum), .avg_out(o4_avg), .min_out(o4_min), .max_out(o4_max), .ovr_out(o4_ovr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      sample = 7'(v);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic res2(input string tag, input int s, input int a, input int mn, input int mx, input int o);
      chk({tag, "_sum"}, 32'(o2_sum), s);
      chk({tag, "_avg"}, 32'(o2_avg), a);
      chk({tag, "_min"}, 32'(o2_min), mn);
      chk({tag, "_max"}, 32'(o2_max), mx);
      chk({tag, "_ovr"}, 32'(o2_ovr), o);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b1;
      tick();
      // reset mid-burst
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      send(7);
      chk("pre_rst_busy", 32'(o2_busy), 1);
      rst = 1'b0;
      #1;
      chk("async_rst_busy", 32'(o2_busy), 0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rst_valid", 32'(o2_valid), 0);
      chk("rst_busy", 32'(o2_busy), 0);
      res2("rst", 0, 0, 0, 0, 0);
      // start cycle with a sample present: sample must be ignored
      start2 = 1'b1;
      sample = 7'd50;
      sample_valid = 1'b1;
      tick();
      start2 = 1'b0;
      sample_valid = 1'b0;
      chk("start_busy", 32'(o2_busy), 1);
      // nominal burst with gaps
      send(10);
      tick();
      send(20);
      tick();
      tick();
      send(30);
      chk("nom_pre_valid", 32'(o2_valid), 0);
      send(40);
      chk("nom_valid", 32'(o2_valid), 1);
      chk("nom_busy", 32'(o2_busy), 1);
      res2("nom", 100, 25, 10, 40, 0);
      // backpressure with stray start during HOLD and on the handshake
      start2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 32'(o2_valid), 1);
         chk("bp_busy", 32'(o2_busy), 1);
         chk("bp_sum", 32'(o2_sum), 100);
      end
      handshake();
      start2 = 1'b0;
      chk("hs_valid", 32'(o2_valid), 0);
      chk("hs_busy", 32'(o2_busy), 0);
      tick();
      chk("hs_idle_busy", 32'(o2_busy), 0);
      res2("idle_keep", 100, 25, 10, 40, 0);
      // clamp
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      send(64);
      send(100);
      send(0);
      send(1);
      chk("clamp_valid", 32'(o2_valid), 1);
      res2("clamp", 129, 32, 0, 64, 1);
      handshake();
      // abort mid-burst
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      send(5);
      send(5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(o2_busy), 0);
      chk("abort_valid", 32'(o2_valid), 0);
      send(5);
      send(5);
      chk("abort_idle_valid", 32'(o2_valid), 0);
      res2("abort_keep", 129, 32, 0, 64, 1);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 4; i++) send(5);
      chk("fresh_valid", 32'(o2_valid), 1);
      res2("fresh", 20, 5, 5, 5, 0);
      // abort in HOLD drops valid but keeps results
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("hold_abort_valid", 32'(o2_valid), 0);
      chk("hold_abort_sum", 32'(o2_sum), 20);
      // extremes on the 16-sample instance
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int i = 0; i < 15; i++) send(64);
      chk("ext_pre_valid", 32'(o4_valid), 0);
      send(64);
      chk("ext_valid", 32'(o4_valid), 1);
      chk("ext_sum", 32'(o4_sum), 1024);
      chk("ext_avg", 32'(o4_avg), 64);
      chk("ext_min", 32'(o4_min), 64);
      chk("ext_max", 32'(o4_max), 64);
      chk("ext_ovr", 32'(o4_ovr), 0);
      handshake();
      chk("ext_hs_busy", 32'(o4_busy), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
